// File: rtl/accum_dump.sv
// accum_dump: integrate-and-dump accumulator with a valid/ready frame result
//   clk, res               clock, synchronous active-high reset
//   in_valid/in_ready      sample handshake, in_data unsigned DW-bit sample
//   dump_len, sat_en, clr  frame length (0 acts as 1), saturate mode, frame abort
//   out_valid/out_ready    result handshake, out_data frame sum, out_ovf overflow
//   acc, busy              live running sum, frame in progress
module accum_dump #(
    parameter int DW = 4,
    parameter int AW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [CW-1:0] dump_len,
    input  logic          sat_en,
    input  logic          clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic          out_ovf,
    output logic [AW-1:0] acc,
    output logic          busy
);
    typedef enum logic {ACC, HOLD} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] acc_q, acc_d, out_data_q, out_data_d, nxt;
    logic [CW-1:0] cnt_q, cnt_d, len_q, len_d, len_eff;
    logic          ovf_q, ovf_d, busy_q, busy_d, out_ovf_q, out_ovf_d, so, last;
    logic [AW:0]   sum;
    assign in_ready  = state_q == ACC;
    assign out_valid = state_q == HOLD;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign acc       = acc_q;
    assign busy      = busy_q;
    always_comb begin
        sum     = {1'b0, acc_q} + {{(AW+1-DW){1'b0}}, in_data};
        so      = sum[AW];
        nxt     = (so && sat_en) ? '1 : sum[AW-1:0];
        // frame length is latched on the first sample so mid-frame edits wait a frame
        len_eff = (cnt_q != '0) ? len_q : (dump_len == '0) ? CW'(1) : dump_len;
        last    = ({1'b0, cnt_q} + (CW+1)'(1)) == {1'b0, len_eff};
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        if (state_q == HOLD) begin
            if (clr || out_ready) state_d = ACC;
        end else if (clr) begin
            acc_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            busy_d = 1'b0;
        end else if (in_valid) begin
            len_d = len_eff;
            if (last) begin
                out_data_d = nxt;
                out_ovf_d  = ovf_q | so;
                state_d    = HOLD;
                acc_d      = '0;
                cnt_d      = '0;
                ovf_d      = 1'b0;
                busy_d     = 1'b0;
            end else begin
                acc_d  = nxt;
                cnt_d  = cnt_q + CW'(1);
                ovf_d  = ovf_q | so;
                busy_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end
endmodule
